mem_access_unit: RTL and testbench

- Load/store front end between the mips core's memory stage and the byte-enable data_mem block RAM (clka, ena, wea[3:0], addra, dina, douta).
- Accepts one request per handshake, then handles the following:
  - byte-lane placement for stores and generation of wea.
  - the one-cycle synchronous BRAM read latency.
  - sign/zero extension for lb/lbu/lh/lhu.
  - misalignment detection.
- Stalls the core until the access completes.

---
 rtl/mem_access_pkg.sv | 36 +++
 rtl/mem_lane_align.sv | 67 ++++++
 rtl/mem_access_unit.sv | 105 ++++++++++
 tb/tb_mem_access_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and the alignment rule for the load/store front end.
package mem_access_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Fields of an accepted request still needed after the handshake.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } req_t;

  // Illegal size 11 always counts as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store mask/replication and load extraction/extension.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]           st_size,
  input  logic [1:0]           st_off,
  input  logic [DATA_W-1:0]    wdata,
  output logic [NUM_LANES-1:0] we_mask,
  output logic [DATA_W-1:0]    wdata_rep,
  input  logic [1:0]           ld_size,
  input  logic                 ld_uns,
  input  logic [1:0]           ld_off,
  input  logic [DATA_W-1:0]    rdata,
  output logic [DATA_W-1:0]    rdata_ext
);

  logic [NUM_LANES-1:0][LANE_W-1:0] wl;
  logic [NUM_LANES-1:0][LANE_W-1:0] rep;

  assign wl        = wdata;
  assign wdata_rep = rep;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LN = 2'(i);
    logic              lane_we;
    logic [LANE_W-1:0] lane_d;

    // Lane i carries byte (i mod access-size) of the right-justified store value.
    always_comb begin
      lane_we = 1'b0;
      lane_d  = wl[i];
      case (st_size)
        SZ_BYTE: begin lane_we = (st_off == LN);       lane_d = wl[0];                end
        SZ_HALF: begin lane_we = (st_off[1] == LN[1]); lane_d = wl[{1'b0, LN[0]}];    end
        SZ_WORD: begin lane_we = 1'b1;                 lane_d = wl[i];                end
        default: begin lane_we = 1'b0;                 lane_d = wl[i];                end
      endcase
    end

    assign we_mask[i] = lane_we;
    assign rep[i]     = lane_d;
  end

  logic [DATA_W-1:0] sh;
  logic              sgn;

  assign sh = rdata >> {ld_off, 3'b000};

  always_comb begin
    sgn       = 1'b0;
    rdata_ext = sh;
    case (ld_size)
      SZ_BYTE: begin
        sgn       = ~ld_uns & sh[7];
        rdata_ext = {{(DATA_W-8){sgn}}, sh[7:0]};
      end
      SZ_HALF: begin
        sgn       = ~ld_uns & sh[15];
        rdata_ext = {{(DATA_W-16){sgn}}, sh[15:0]};
      end
      default: rdata_ext = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the byte-enable data_mem BRAM; stalls the core until done.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              addr_err,
  output logic              stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state, state_nxt;
  req_t   req_q;

  logic                 acc, bad;
  logic                 mem_en_q;
  logic [NUM_LANES-1:0] mem_we_q, we_mask;
  logic [DATA_W-1:0]    wdata_rep, rdata_ext;

  assign acc = (state == IDLE) && req_valid;
  assign bad = misaligned(req_size, req_addr[1:0]);

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_size   (req_size),
    .st_off    (req_addr[1:0]),
    .wdata     (req_wdata),
    .we_mask   (we_mask),
    .wdata_rep (wdata_rep),
    .ld_size   (req_q.size),
    .ld_uns    (req_q.uns),
    .ld_off    (req_q.off),
    .rdata     (mem_rdata),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = bad ? RESP : ISSUE;
      ISSUE:   state_nxt = req_q.we ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    stall     = acc || (state == ISSUE) || (state == WAIT);
  end

  // Strobes are launched at the accept edge so they are live during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      addr_err   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_en_q   <= acc && !bad;
      mem_we_q   <= (acc && !bad && req_we) ? we_mask : '0;
      resp_valid <= (state_nxt == RESP);
      if (acc) begin
        req_q    <= '{we: req_we, size: req_size, uns: req_unsigned, off: req_addr[1:0]};
        addr_err <= bad;
        if (!bad) begin
          mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
          if (req_we) mem_wdata <= wdata_rep;
        end
      end
      if ((acc && bad) || ((state == ISSUE) && req_q.we)) resp_rdata <= '0;
      else if (state == WAIT)                             resp_rdata <= rdata_ext;
    end
  end

  // Reset must cancel a write already presented in ISSUE before the BRAM samples it.
  assign mem_en = mem_en_q & ~rst;
  assign mem_we = mem_we_q & {NUM_LANES{~rst}};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random bench for mem_access_unit against a byte-array reference memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, addr_err, stall, mem_en;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .addr_err(addr_err), .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // data_mem stand-in: one-cycle registered read, per-byte write enables.
  logic [31:0] bram [0:255];
  logic        clr;
  int          bram_writes = 0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) bram[i] <= 32'h0;
    end else if (mem_en) begin
      mem_rdata <= bram[mem_addr[9:2]];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) bram[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      if (|mem_we) bram_writes++;
    end
  end

  logic [7:0] ref_mem [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},      32'(req_ready),  32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    chk({tag, "_addr_err"},   32'(addr_err),   32'd0);
    chk({tag, "_mem_en"},     32'(mem_en),     32'd0);
    chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
    chk({tag, "_mem_addr"},   mem_addr,        32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
  endtask

  // One request: expectations come from the size/alignment rules and ref_mem bytes.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input bit hold,
                      input string tag);
    logic        err;
    int          nb, cyc, ens, wrs, stl, w0, lat;
    logic [31:0] exp_rd, exp_mask, exp_wd;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    nb  = 1 << sz;
    lat = err ? 1 : (we ? 2 : 3);
    exp_rd = 32'h0;
    if (!err && !we) begin
      for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = ref_mem[int'(a[9:0]) + k];
      if (!uns && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | ~((32'h1 << (8*nb)) - 32'h1);
    end
    exp_mask = 32'(((1 << nb) - 1) << a[1:0]);
    exp_wd   = 32'h0;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];

    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    #1;
    chk({tag, "_ready"},      32'(req_ready),  32'd1);
    chk({tag, "_stall0"},     32'(stall),      32'd1);
    chk({tag, "_no_resp0"},   32'(resp_valid), 32'd0);
    cyc = 0; ens = 0; wrs = 0; stl = 0; w0 = bram_writes;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        ens++;
        chk({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
      end
      if (|mem_we) begin
        wrs++;
        chk({tag, "_mem_we"},    32'(mem_we), exp_mask);
        chk({tag, "_mem_wdata"}, mem_wdata,   exp_wd);
      end
      if (resp_valid) break;
      if (stall) stl++;
    end
    chk({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
    chk({tag, "_latency"},   32'(cyc),        32'(lat));
    chk({tag, "_stall_cyc"}, 32'(stl),        32'(lat - 1));
    chk({tag, "_stall_rsp"}, 32'(stall),      32'd0);
    chk({tag, "_addr_err"},  32'(addr_err),   32'(err));
    chk({tag, "_rdata"},     resp_rdata,      exp_rd);
    chk({tag, "_en_cnt"},    32'(ens),        32'(err ? 0 : 1));
    chk({tag, "_wr_cnt"},    32'(wrs),        32'((we && !err) ? 1 : 0));
    chk({tag, "_bram_wr"},   32'(bram_writes - w0), 32'((we && !err) ? 1 : 0));
    if (we && !err)
      for (int k = 0; k < nb; k++) ref_mem[int'(a[9:0]) + k] = wd[8*k +: 8];
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
    rst = 1'b1; clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    chk("por_stall", 32'(stall), 32'd0);
    rst = 1'b0; clr = 1'b0;

    xact(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00A5, 1'b0, "sb13");
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01, 1'b0, "sw20");
    xact(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 1'b0, "lb22");
    xact(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b0, "lbu23");
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, "lw20");
    xact(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_BEEF, 1'b0, "sh32");
    xact(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b0, "lh32");
    xact(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0, "lhu32");
    xact(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 1'b0, "lw41_err");
    xact(1'b1, 2'b01, 1'b0, 32'h41, 32'h1234, 1'b0, "sh41_err");
    xact(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0, "sz11_err");

    // Reset during the ISSUE cycle of a store must suppress the write.
    xact(1'b1, 2'b10, 1'b0, 32'h50, 32'h1234_5678, 1'b0, "sw50");
    xact(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0, "lw50_pre");
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h50; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    w0 = bram_writes;
    @(posedge clk);
    #1 rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("rst_issue_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk_reset_vals("rst_mid");
    chk("rst_mid_bram_wr", 32'(bram_writes - w0), 32'd0);
    rst = 1'b0;
    xact(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0, "lw50_post");

    xact(1'b1, 2'b10, 1'b0, 32'h60, 32'hCAFE_F00D, 1'b1, "b2b_sw");
    xact(1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 1'b1, "b2b_lw");
    xact(1'b0, 2'b00, 1'b0, 32'h63, 32'h0, 1'b0, "b2b_lb");

    for (int n = 0; n < 60; n++) begin
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           32'h100 + 32'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)), "rnd");
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
